// File: rtl/ysyx_23060096_fetch_ctrl.sv
// rtl/ysyx_23060096_fetch_ctrl.sv - instruction-fetch sequencer: PC owner, imem request/response, decode handshake
module ysyx_23060096_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        misalign_err,
  output logic [31:0] inst_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_e;

  state_e      state_q, state_d, resume_state;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;
  logic        misalign_q, misalign_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    inst_cnt_d   = inst_cnt_q;
    misalign_d   = redirect_valid && (redirect_pc[1:0] != 2'b00);
    resume_state = fetch_en ? REQ : IDLE;

    case (state_q)
      IDLE: begin
        if (fetch_en) state_d = REQ;
      end
      REQ: begin
        // An accepted request must still be drained even if a redirect arrives now.
        if (imem_req_ready) begin
          state_d = WAIT;
          drop_d  = redirect_valid;
        end else if (!fetch_en) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = resume_state;
          end else begin
            out_pc_d   = pc_q;
            out_inst_d = imem_rsp_data;
            state_d    = OUT;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          inst_cnt_d = inst_cnt_q + 32'd1;
          pc_d       = pc_q + PC_STEP;
          state_d    = resume_state;
        end else if (redirect_valid) begin
          state_d = resume_state;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) pc_d = {redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      out_pc_q   <= '0;
      out_inst_q <= '0;
      inst_cnt_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      out_pc_q   <= out_pc_d;
      out_inst_q <= out_inst_d;
      inst_cnt_q <= inst_cnt_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == OUT);
  assign out_pc         = out_pc_q;
  assign out_inst       = out_inst_q;
  assign misalign_err   = misalign_q;
  assign inst_cnt       = inst_cnt_q;

endmodule

// File: tb/tb_ysyx_23060096_fetch_ctrl.sv
// tb/tb_ysyx_23060096_fetch_ctrl.sv - directed self-checking bench for ysyx_23060096_fetch_ctrl
module tb_ysyx_23060096_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        misalign_err;
  logic [31:0] inst_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int rsp_delay = 0;
  int cyc = 0;

  ysyx_23060096_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .misalign_err(misalign_err),
    .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // Memory model: a request seen accepted at a falling edge is answered
  // rsp_delay cycles after the accepting edge, for exactly one cycle.
  initial begin
    logic [31:0] ra;
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        ra = imem_req_addr;
        repeat (rsp_delay) @(posedge clk);
        @(posedge clk); #1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = inst_of(ra);
        @(posedge clk); #1;
        imem_rsp_valid = 1'b0;
      end
    end
  end

  task automatic wait_accept(output logic [31:0] a, output int at);
    a = '0; at = 0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req_valid && imem_req_ready) begin
        a = imem_req_addr; at = cyc;
        return;
      end
      @(negedge clk);
    end
    n_cmp++; n_bad++;
    $display("FAIL accept_timeout: got no accepted request, wanted one within 50 cycles");
  endtask

  task automatic wait_out(output logic [31:0] p, output logic [31:0] d);
    p = '0; d = '0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        p = out_pc; d = out_inst;
        return;
      end
      @(negedge clk);
    end
    n_cmp++; n_bad++;
    $display("FAIL out_timeout: got no out_valid, wanted one within 50 cycles");
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
    imem_req_ready = 1'b1; rsp_delay = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, imem_req_valid, misalign_err} !== 3'b000) begin
      n_bad++; $display("FAIL reset_valids: got %b want 000", {out_valid, imem_req_valid, misalign_err});
    end
    n_cmp++;
    if (imem_req_addr !== 32'h8000_0000) begin
      n_bad++; $display("FAIL reset_pc: got %h want 80000000", imem_req_addr);
    end
    n_cmp++;
    if ({out_pc, out_inst, inst_cnt} !== 96'd0) begin
      n_bad++; $display("FAIL reset_regs: got %h %h %h want zeros", out_pc, out_inst, inst_cnt);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a, p, d;
    int t, t_prev;
    do_reset();
    fetch_en = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_accept(a, t);
      n_cmp++;
      if (a !== 32'h8000_0000 + 32'(4 * i)) begin
        n_bad++; $display("FAIL seq_addr%0d: got %h want %h", i, a, 32'h8000_0000 + 32'(4 * i));
      end
      if (i > 0) begin
        n_cmp++;
        if (t - t_prev !== 3) begin
          n_bad++; $display("FAIL seq_throughput%0d: got %0d cycles want 3", i, t - t_prev);
        end
      end
      t_prev = t;
      wait_out(p, d);
      n_cmp++;
      if ({p, d} !== {32'h8000_0000 + 32'(4 * i), inst_of(32'h8000_0000 + 32'(4 * i))}) begin
        n_bad++; $display("FAIL seq_out%0d: got %h/%h want %h/%h", i, p, d,
                          32'h8000_0000 + 32'(4 * i), inst_of(32'h8000_0000 + 32'(4 * i)));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (inst_cnt !== 32'd3) begin
      n_bad++; $display("FAIL seq_cnt: got %0d want 3", inst_cnt);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a, p, d;
    int t;
    do_reset();
    out_ready = 1'b0; fetch_en = 1'b1;
    wait_out(p, d);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({out_valid, imem_req_valid, out_pc, out_inst} !== {2'b10, 32'h8000_0000, inst_of(32'h8000_0000)}) begin
        n_bad++; $display("FAIL stall_hold%0d: got v=%b req=%b %h/%h want v=1 req=0 80000000/%h",
                          i, out_valid, imem_req_valid, out_pc, out_inst, inst_of(32'h8000_0000));
      end
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_accept(a, t);
    n_cmp++;
    if (a !== 32'h8000_0004) begin
      n_bad++; $display("FAIL stall_next_addr: got %h want 80000004", a);
    end
    n_cmp++;
    if (inst_cnt !== 32'd1) begin
      n_bad++; $display("FAIL stall_cnt: got %0d want 1", inst_cnt);
    end
  endtask

  task automatic test_redirect_wait();
    logic [31:0] a, p, d;
    int t;
    logic seen;
    do_reset();
    rsp_delay = 2; fetch_en = 1'b1;
    wait_accept(a, t);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    @(posedge clk); #1;
    redirect_valid = 1'b0; rsp_delay = 0;
    seen = 1'b0; a = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      if (imem_req_valid && imem_req_ready) begin
        a = imem_req_addr;
        break;
      end
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL redir_drop: got out_valid=1 want dropped response");
    end
    n_cmp++;
    if (a !== 32'h8000_0100) begin
      n_bad++; $display("FAIL redir_addr: got %h want 80000100", a);
    end
    n_cmp++;
    if (inst_cnt !== 32'd0) begin
      n_bad++; $display("FAIL redir_cnt: got %0d want 0", inst_cnt);
    end
    wait_out(p, d);
    n_cmp++;
    if ({p, d} !== {32'h8000_0100, inst_of(32'h8000_0100)}) begin
      n_bad++; $display("FAIL redir_out: got %h/%h want 80000100/%h", p, d, inst_of(32'h8000_0100));
    end
  endtask

  task automatic test_redirect_out();
    logic [31:0] p, d;
    do_reset();
    out_ready = 1'b0; fetch_en = 1'b1;
    wait_out(p, d);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, imem_req_valid, imem_req_addr, inst_cnt} !== {2'b01, 32'h8000_0200, 32'd0}) begin
      n_bad++; $display("FAIL redir_out_discard: got v=%b req=%b %h cnt=%0d want v=0 req=1 80000200 cnt=0",
                        out_valid, imem_req_valid, imem_req_addr, inst_cnt);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] a;
    int t;
    do_reset();
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    @(negedge clk);
    n_cmp++;
    if (misalign_err !== 1'b0) begin
      n_bad++; $display("FAIL mis_early: got %b want 0", misalign_err);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0; fetch_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (misalign_err !== 1'b1) begin
      n_bad++; $display("FAIL mis_pulse: got %b want 1", misalign_err);
    end
    @(negedge clk);
    n_cmp++;
    if (misalign_err !== 1'b0) begin
      n_bad++; $display("FAIL mis_clear: got %b want 0", misalign_err);
    end
    wait_accept(a, t);
    n_cmp++;
    if (a !== 32'h8000_0100) begin
      n_bad++; $display("FAIL mis_addr: got %h want 80000100", a);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a, p, d;
    int t;
    do_reset();
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    force dut.inst_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.inst_cnt_q;
    fetch_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (inst_cnt !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL wrap_preload: got %h want ffffffff", inst_cnt);
    end
    wait_accept(a, t);
    n_cmp++;
    if (a !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL wrap_first: got %h want fffffffc", a);
    end
    wait_out(p, d);
    n_cmp++;
    if ({p, d} !== {32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC)}) begin
      n_bad++; $display("FAIL wrap_out: got %h/%h want fffffffc/%h", p, d, inst_of(32'hFFFF_FFFC));
    end
    wait_accept(a, t);
    n_cmp++;
    if (a !== 32'h0000_0000) begin
      n_bad++; $display("FAIL wrap_pc: got %h want 00000000", a);
    end
    n_cmp++;
    if (inst_cnt !== 32'd0) begin
      n_bad++; $display("FAIL wrap_cnt: got %h want 00000000", inst_cnt);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] a, p, d;
    int t;
    do_reset();
    fetch_en = 1'b1;
    @(posedge clk); #1 fetch_en = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_accept(a, t);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({imem_rsp_valid, out_valid, imem_req_valid, imem_req_addr} !== {3'b100, 32'h8000_0000}) begin
      n_bad++; $display("FAIL rstmid_state: got rsp=%b v=%b req=%b %h want rsp=1 v=0 req=0 80000000",
                        imem_rsp_valid, out_valid, imem_req_valid, imem_req_addr);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    wait_accept(a, t);
    n_cmp++;
    if (a !== 32'h8000_0000) begin
      n_bad++; $display("FAIL rstmid_first: got %h want 80000000", a);
    end
    wait_out(p, d);
    n_cmp++;
    if ({p, d, inst_cnt} !== {32'h8000_0000, inst_of(32'h8000_0000), 32'd0}) begin
      n_bad++; $display("FAIL rstmid_out: got %h/%h cnt=%0d want 80000000/%h cnt=0",
                        p, d, inst_cnt, inst_of(32'h8000_0000));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_out();
    test_misalign();
    test_wrap();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, wanted summary before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
